// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC stage: run-control state encoding,
// instruction step and default reset PC.
package next_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam int unsigned PC_STEP      = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/next_pc_unit_pc_target_gen.sv
// Combinational candidate-PC generator: sequential, branch and aligned jr
// targets, plus the jr misalignment flag. All sums wrap modulo 2^ADDR_W.
module pc_target_gen
    import next_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 26
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [OFF_W-1:0]  i_br_offset,
    input  logic [ADDR_W-1:0] i_jr_target,
    output logic [ADDR_W-1:0] o_seq_tgt,
    output logic [ADDR_W-1:0] o_br_tgt,
    output logic [ADDR_W-1:0] o_jr_tgt,
    output logic              o_jr_misalign
);

    logic [ADDR_W-1:0] w_off_ext;

    // Word offset: sign-extend to address width, then scale to bytes.
    assign w_off_ext     = {{(ADDR_W-OFF_W){i_br_offset[OFF_W-1]}}, i_br_offset};
    assign o_seq_tgt     = i_pc + ADDR_W'(PC_STEP);
    assign o_br_tgt      = o_seq_tgt + (w_off_ext << 2);
    assign o_jr_tgt      = {i_jr_target[ADDR_W-1:2], 2'b00};
    assign o_jr_misalign = |i_jr_target[1:0];

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage with IDLE/RUN/HALT run control and next-PC priority mux.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                OFF_W    = 26,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pc_en,
    input  logic              i_halt_req,
    input  logic              i_is_cond_br,
    input  logic              i_br_success,
    input  logic              i_is_uncond_br,
    input  logic              i_is_jr,
    input  logic [OFF_W-1:0]  i_br_offset,
    input  logic [ADDR_W-1:0] i_jr_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_link_addr,
    output logic              o_redirect,
    output logic              o_running,
    output logic              o_halted,
`ifdef BRANCH_STATS_EN
    output logic [31:0]       o_br_taken_cnt,
    output logic [31:0]       o_br_not_taken_cnt,
`endif
    output logic              o_misalign_err
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_redirect, w_redirect_nxt;
    logic              r_misalign, w_misalign_nxt;

    logic [ADDR_W-1:0] w_seq_tgt, w_br_tgt, w_jr_tgt;
    logic              w_jr_mis;

    pc_target_gen #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_tgt (
        .i_pc          (r_pc),
        .i_br_offset   (i_br_offset),
        .i_jr_target   (i_jr_target),
        .o_seq_tgt     (w_seq_tgt),
        .o_br_tgt      (w_br_tgt),
        .o_jr_tgt      (w_jr_tgt),
        .o_jr_misalign (w_jr_mis)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // Priority: halt > jr > uncond > taken cond > sequential. Stalls hold everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = r_redirect;
        w_misalign_nxt = r_misalign;
        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = RESET_PC;
                if (i_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_pc_en) begin
                    w_redirect_nxt = 1'b1;
                    if (i_halt_req) begin
                        w_state_nxt    = ST_HALT;
                        w_redirect_nxt = 1'b0;
                    end else if (i_is_jr) begin
                        w_pc_nxt = w_jr_tgt;
                        if (w_jr_mis) w_misalign_nxt = 1'b1;
                    end else if (i_is_uncond_br) begin
                        w_pc_nxt = w_br_tgt;
                    end else if (i_is_cond_br && i_br_success) begin
                        w_pc_nxt = w_br_tgt;
                    end else begin
                        w_pc_nxt       = w_seq_tgt;
                        w_redirect_nxt = 1'b0;
                    end
                end
            end
            ST_HALT: ;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_pc           = r_pc;
    assign o_link_addr    = w_seq_tgt;
    assign o_redirect     = r_redirect;
    assign o_running      = (r_state == ST_RUN);
    assign o_halted       = (r_state == ST_HALT);
    assign o_misalign_err = r_misalign;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_taken_cnt, r_br_not_taken_cnt;
    logic        w_stat_qual;

    assign w_stat_qual = (r_state == ST_RUN) && i_pc_en && i_is_cond_br;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_taken_cnt     <= '0;
            r_br_not_taken_cnt <= '0;
        end else if (w_stat_qual) begin
            if (i_br_success && (r_br_taken_cnt != '1))
                r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
            if (!i_br_success && (r_br_not_taken_cnt != '1))
                r_br_not_taken_cnt <= r_br_not_taken_cnt + 32'd1;
        end
    end

    assign o_br_taken_cnt     = r_br_taken_cnt;
    assign o_br_not_taken_cnt = r_br_not_taken_cnt;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit; stats checks compile in with BRANCH_STATS_EN.
module tb_next_pc_unit;

    typedef struct packed {
        logic        start, en, halt, cb, bs, ub, jr;
        logic [25:0] off;
        logic [31:0] jt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rd, run, hlt, mis;
        logic [31:0] lnk;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 0, pc_en = 0, halt_req = 0, is_cond_br = 0, br_success = 0;
    logic        is_uncond_br = 0, is_jr = 0;
    logic [25:0] br_offset = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc, link_addr;
    logic        redirect, running, halted, misalign_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_taken_cnt, br_not_taken_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    localparam logic [25:0] OFF_M2 = 26'h3FF_FFFE;
    localparam logic [25:0] OFF_M1 = 26'h3FF_FFFF;

    always #5 clk = ~clk;

    next_pc_unit dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_pc_en            (pc_en),
        .i_halt_req         (halt_req),
        .i_is_cond_br       (is_cond_br),
        .i_br_success       (br_success),
        .i_is_uncond_br     (is_uncond_br),
        .i_is_jr            (is_jr),
        .i_br_offset        (br_offset),
        .i_jr_target        (jr_target),
        .o_pc               (pc),
        .o_link_addr        (link_addr),
        .o_redirect         (redirect),
        .o_running          (running),
        .o_halted           (halted),
`ifdef BRANCH_STATS_EN
        .o_br_taken_cnt     (br_taken_cnt),
        .o_br_not_taken_cnt (br_not_taken_cnt),
`endif
        .o_misalign_err     (misalign_err)
    );

    function automatic stim_t mk(logic st, logic en, logic hl, logic cb, logic bs,
                                 logic ub, logic jr, logic [25:0] off, logic [31:0] jt);
        stim_t s;
        s = '{start: st, en: en, halt: hl, cb: cb, bs: bs, ub: ub, jr: jr, off: off, jt: jt};
        return s;
    endfunction

    function automatic out_t ex(logic [31:0] p, logic rd, logic run, logic hlt, logic mis);
        out_t o;
        o = '{pc: p, rd: rd, run: run, hlt: hlt, mis: mis, lnk: p + 32'd4};
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = '{pc: pc, rd: redirect, run: running, hlt: halted, mis: misalign_err, lnk: link_addr};
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("pc=%h rd=%b run=%b hlt=%b mis=%b lnk=%h", o.pc, o.rd, o.run, o.hlt, o.mis, o.lnk);
    endfunction

    // Drive one cycle of stimulus, queue its expectation, pop it once the edge is past.
    task automatic cyc(input stim_t s, input out_t e, output out_t got, output out_t want);
        start = s.start; pc_en = s.en; halt_req = s.halt; is_cond_br = s.cb;
        br_success = s.bs; is_uncond_br = s.ub; is_jr = s.jr;
        br_offset = s.off; jr_target = s.jt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        got  = sample();
        want = exp_q.pop_front();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; pc_en = 0; halt_req = 0; is_cond_br = 0; br_success = 0;
        is_uncond_br = 0; is_jr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        out_t got, want;
        do_reset();
        got = sample(); want = ex(32'h0, 0, 0, 0, 0);
        checks++;
        if (got !== want) begin errors++; $display("FAIL reset got %s want %s", fmt(got), fmt(want)); end
`ifdef BRANCH_STATS_EN
        checks++;
        if (br_taken_cnt !== 32'd0 || br_not_taken_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", br_taken_cnt, br_not_taken_cnt);
        end
`endif
        cyc(mk(0,1,0,1,1,0,0,26'd4,32'h0), ex(32'h0, 0, 0, 0, 0), got, want);
        checks++;
        if (got !== want) begin errors++; $display("FAIL idle_hold got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_sequential();
        stim_t st[4]; out_t e[4]; out_t got, want;
        st[0] = mk(1,1,0,0,0,0,0,0,0); e[0] = ex(32'h0, 0, 1, 0, 0);
        st[1] = mk(0,1,0,0,0,0,0,0,0); e[1] = ex(32'h4, 0, 1, 0, 0);
        st[2] = mk(0,1,0,0,0,0,0,0,0); e[2] = ex(32'h8, 0, 1, 0, 0);
        st[3] = mk(0,1,0,0,0,0,0,0,0); e[3] = ex(32'hC, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL seq[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_cond_branch();
        stim_t st[4]; out_t e[4]; out_t got, want;
        st[0] = mk(0,1,0,0,0,0,0,0,0);      e[0] = ex(32'h10, 0, 1, 0, 0);
        st[1] = mk(0,1,0,1,1,0,0,OFF_M2,0); e[1] = ex(32'h0C, 1, 1, 0, 0);
        st[2] = mk(0,1,0,0,0,0,0,0,0);      e[2] = ex(32'h10, 0, 1, 0, 0);
        st[3] = mk(0,1,0,1,0,0,0,OFF_M2,0); e[3] = ex(32'h14, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL cond[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_jr_priority();
        stim_t st[7]; out_t e[7]; out_t got, want;
        st[0] = mk(0,1,0,0,0,0,0,0,0);              e[0] = ex(32'h18, 0, 1, 0, 0);
        st[1] = mk(0,1,0,0,0,0,0,0,0);              e[1] = ex(32'h1C, 0, 1, 0, 0);
        st[2] = mk(0,1,0,0,0,0,0,0,0);              e[2] = ex(32'h20, 0, 1, 0, 0);
        st[3] = mk(0,1,0,0,0,1,1,26'd5,32'h102);    e[3] = ex(32'h100, 1, 1, 0, 1);
        st[4] = mk(0,1,0,0,0,0,0,0,0);              e[4] = ex(32'h104, 0, 1, 0, 1);
        st[5] = mk(0,1,0,0,0,1,0,OFF_M1,0);         e[5] = ex(32'h104, 1, 1, 0, 1);
        st[6] = mk(0,1,0,1,1,1,0,26'd2,0);          e[6] = ex(32'h110, 1, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL jr[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_stall_halt();
        stim_t st[5]; out_t e[5]; out_t got, want;
        st[0] = mk(0,0,1,0,0,0,0,0,0);             e[0] = ex(32'h110, 1, 1, 0, 1);
        st[1] = mk(0,0,1,1,1,0,0,26'd8,0);         e[1] = ex(32'h110, 1, 1, 0, 1);
        st[2] = mk(0,1,1,0,0,0,1,0,32'h3);         e[2] = ex(32'h110, 0, 0, 1, 1);
        st[3] = mk(1,1,0,1,1,0,0,26'd8,0);         e[3] = ex(32'h110, 0, 0, 1, 1);
        st[4] = mk(0,1,0,0,0,1,1,26'd3,32'h200);   e[4] = ex(32'h110, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL halt[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_wrap_reset();
        stim_t st[5]; out_t e[5]; out_t got, want;
        do_reset();
        got = sample(); want = ex(32'h0, 0, 0, 0, 0);
        checks++;
        if (got !== want) begin errors++; $display("FAIL halt_exit_reset got %s want %s", fmt(got), fmt(want)); end
        st[0] = mk(1,1,0,0,0,0,0,0,0);        e[0] = ex(32'h0, 0, 1, 0, 0);
        st[1] = mk(0,1,0,1,1,0,0,OFF_M2,0);   e[1] = ex(32'hFFFF_FFFC, 1, 1, 0, 0);
        st[2] = mk(0,1,0,0,0,0,0,0,0);        e[2] = ex(32'h0, 0, 1, 0, 0);
        st[3] = mk(0,1,0,0,0,0,1,0,32'h1000); e[3] = ex(32'h1000, 1, 1, 0, 0);
        st[4] = mk(0,1,0,0,0,0,0,0,0);        e[4] = ex(32'h1004, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL wrap[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample(); want = ex(32'h0, 0, 0, 0, 0);
        checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset got %s want %s", fmt(got), fmt(want)); end
        rst_n = 1'b1;
        cyc(mk(0,1,0,0,0,0,0,0,0), ex(32'h0, 0, 0, 0, 0), got, want);
        checks++;
        if (got !== want) begin errors++; $display("FAIL post_reset_idle got %s want %s", fmt(got), fmt(want)); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_branch_stats();
        stim_t st[7]; out_t e[7]; out_t got, want;
        do_reset();
        st[0] = mk(1,1,0,0,0,0,0,0,0); e[0] = ex(32'h0,  0, 1, 0, 0);
        st[1] = mk(0,1,0,1,1,0,0,0,0); e[1] = ex(32'h4,  1, 1, 0, 0);
        st[2] = mk(0,1,0,1,1,0,0,0,0); e[2] = ex(32'h8,  1, 1, 0, 0);
        st[3] = mk(0,1,0,1,1,0,0,0,0); e[3] = ex(32'hC,  1, 1, 0, 0);
        st[4] = mk(0,1,0,1,0,0,0,0,0); e[4] = ex(32'h10, 0, 1, 0, 0);
        st[5] = mk(0,1,0,1,0,0,0,0,0); e[5] = ex(32'h14, 0, 1, 0, 0);
        st[6] = mk(0,0,0,1,1,0,0,0,0); e[6] = ex(32'h14, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(st[i], e[i], got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL stats_pc[%0d] got %s want %s", i, fmt(got), fmt(want)); end
        end
        checks++;
        if (br_taken_cnt !== 32'd3) begin errors++; $display("FAIL taken_cnt got %0d want 3", br_taken_cnt); end
        checks++;
        if (br_not_taken_cnt !== 32'd2) begin errors++; $display("FAIL not_taken_cnt got %0d want 2", br_not_taken_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_cond_branch();
        test_jr_priority();
        test_stall_halt();
        test_wrap_reset();
`ifdef BRANCH_STATS_EN
        test_branch_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Program-counter stage directly downstream of the branch-comparison success logic.
- Holds the architectural PC and selects each next PC from sequential, conditional-branch (bz/bnz/bltz), unconditional-branch (b/bl) and register-jump (jr) sources.
- Provides the fetch address and the bl link value to the datapath, and runs a small run-control FSM (IDLE/RUN/HALT).

Parameters:
- ADDR_W, 32, width of PC and all address paths.
- OFF_W, 26, width of the signed word offset field carried by branch instructions.
- RESET_PC, 32'h0000_0000, PC value on reset and while in IDLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; leaves IDLE.
- pc_en  input  1  1 = PC may advance this cycle; 0 = stall (hold).
- halt_req  input  1  controller decoded halt instruction.
- is_cond_br  input  1  instruction is bz/bnz/bltz.
- br_success  input  1  comparison result from the branch success logic.
- is_uncond_br  input  1  instruction is b or bl.
- is_jr  input  1  instruction is jr.
- br_offset  input  OFF_W  signed word offset.
- jr_target  input  ADDR_W  register value for jr.
- pc  output  ADDR_W  current fetch address (registered).
- link_addr  output  ADDR_W  pc + 4 (combinational), written to ra by bl.
- redirect  output  1  registered; 1 if the last PC update was non-sequential.
- running  output  1  FSM in RUN.
- halted  output  1  FSM in HALT.
- misalign_err  output  1  sticky; jr target had nonzero bits [1:0].

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, redirect=0, misalign_err=0, state=IDLE.
  - Takes effect immediately, including mid-operation; all in-flight selections are discarded.
- FSM:
  - IDLE: pc held at RESET_PC; running=0, halted=0. Moves to RUN on the next edge when start=1. start is ignored outside IDLE.
  - RUN: the PC updates each edge when pc_en=1. If halt_req=1 and pc_en=1, move to HALT; pc is held at the halt instruction address and redirect=0.
  - HALT: pc frozen; all inputs ignored. Left only by reset.
- Target computation:
  - Branch target = pc + 4 + (sign_extend(br_offset) << 2). Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  - Sequential target = pc + 4, also wrapping (32'hFFFF_FFFC -> 0).
  - jr target = {jr_target[ADDR_W-1:2], 2'b00}. When jr_target[1:0] != 0, set misalign_err (sticky until reset).
- Next-PC priority in RUN with pc_en=1, highest first:
  - halt_req
  - is_jr
  - is_uncond_br
  - is_cond_br && br_success
  - sequential
- Conflicting decode (more than one of is_jr, is_uncond_br, is_cond_br high) resolves by that priority and raises no error.
- redirect: 1 for one cycle after any jr, unconditional or taken-conditional update; 0 after sequential, not-taken or halt updates.
- Stall: pc_en=0 holds pc, redirect, state and misalign_err. A halt_req or branch during a stall has no effect until pc_en=1.
- Latency: the selected next PC appears on pc one edge after the qualifying cycle. link_addr follows pc combinationally.

Optional Feature:
- BRANCH_STATS_EN compiles in two 32-bit saturating counters:
  - br_taken_cnt: conditional branches with br_success=1, counted only in RUN with pc_en=1.
  - br_not_taken_cnt: conditional branches with br_success=0, same qualification.
- Both counters clear on reset and are added as output ports.
- Without the macro, neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, RUN=2'b01, HALT=2'b10.
  - Instruction-step constant PC_STEP=4.
  - RESET_PC default.
- One natural sub-module: pc_target_gen. It is purely combinational and computes the sequential, branch and aligned jr targets plus the misalign flag. The top level keeps the FSM, priority mux and registers.

Test Plan:
1. Reset, then start pulse with pc_en=1 and no branches for 3 cycles -> pc goes 0, 4, 8, 0xC; running=1; redirect=0.
2. At pc=0x10: is_cond_br=1, br_success=1, br_offset=-2 -> pc=0x0C, redirect=1. Repeat with br_success=0 -> pc=0x14, redirect=0.
3. At pc=0x20: is_jr=1, is_uncond_br=1, jr_target=0x102, br_offset=5 -> pc=0x100 (jr wins), misalign_err=1 and stays 1 afterwards.
4. Stall plus halt: pc_en=0 with halt_req=1 for 2 cycles -> pc and state unchanged. pc_en=1 -> HALT, halted=1, pc frozen; a later start and branches are ignored.
5. pc=0xFFFF_FFFC with sequential step -> pc=0, no error. Assert rst mid-RUN between edges -> pc=RESET_PC and IDLE immediately, without waiting for a clock edge.
6. BRANCH_STATS_EN defined: 3 taken and 2 not-taken conditional branches, plus 1 taken branch during a stall -> br_taken_cnt=3, br_not_taken_cnt=2.
